// File: rtl/mips_uart_tx_ctrl_if.sv
// Signal bundle between the core's UART store port, the transmit scheduler
// and the byte-wide UART transmitter.
interface mips_uart_tx_ctrl_if #(
    parameter int LENGTH = 32,
    parameter int DEPTH  = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic              wr_en;
    logic [LENGTH-1:0] wr_data;
    logic              UART_Done;
    logic              tx_start;
    logic [7:0]        tx_byte;
    logic              busy;
    logic              full;
    logic [CW-1:0]     count;
    logic              overflow;

    modport master (
        output wr_en, wr_data, UART_Done,
        input  tx_start, tx_byte, busy, full, count, overflow
    );

    modport slave (
        input  wr_en, wr_data, UART_Done,
        output tx_start, tx_byte, busy, full, count, overflow
    );
endinterface

// File: rtl/mips_uart_tx_ctrl.sv
// Buffers core stores in a small word FIFO and feeds them LSB-first, one byte
// per tx_start, to the UART, advancing on each rising edge of UART_Done.
module mips_uart_tx_ctrl #(
    parameter int LENGTH = 32,
    parameter int DEPTH  = 4
) (
    input  logic               clock,
    input  logic               reset,
    mips_uart_tx_ctrl_if.slave bus
);
    localparam int BYTES = LENGTH / 8;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;

    state_t            state_q;
    logic [LENGTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic              full_q;
    logic              full_d;
    logic              overflow_q;
    logic              done_q;
    logic [LENGTH-1:0] shreg_q;
    logic [LENGTH-1:0] shreg_d;
    logic [BW-1:0]     byte_idx_q;
    logic [7:0]        tx_byte_q;
    logic              tx_start_q;
    logic              push;
    logic              pop;
    logic              done_rise;

    assign push      = bus.wr_en & ~full_q;
    assign pop       = (state_q == LOAD);
    assign done_rise = bus.UART_Done & ~done_q;
    // Rotate rather than shift: only the low byte is ever observed.
    assign shreg_d   = LENGTH'({shreg_q, shreg_q} >> 8);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    assign full_d = (count_d == CW'(DEPTH));

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q  <= bus.UART_Done;
            count_q <= count_d;
            full_q  <= full_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            // A write against a full FIFO is lost even if a pop frees a slot this cycle.
            if (bus.wr_en && full_q) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            tx_start_q <= 1'b0;
            tx_byte_q  <= 8'h00;
            shreg_q    <= '0;
            byte_idx_q <= '0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    shreg_q    <= mem_q[rd_ptr_q];
                    tx_byte_q  <= mem_q[rd_ptr_q][7:0];
                    byte_idx_q <= '0;
                    tx_start_q <= 1'b1;
                    state_q    <= SEND;
                end
                SEND: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (done_rise) begin
                        if (byte_idx_q == BW'(BYTES - 1)) begin
                            state_q <= IDLE;
                        end else begin
                            shreg_q    <= shreg_d;
                            tx_byte_q  <= shreg_d[7:0];
                            byte_idx_q <= byte_idx_q + 1'b1;
                            tx_start_q <= 1'b1;
                            state_q    <= SEND;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_start = tx_start_q;
    assign bus.tx_byte  = tx_byte_q;
    assign bus.busy     = (state_q != IDLE) | (count_q != '0);
    assign bus.full     = full_q;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_mips_uart_tx_ctrl.sv
// Scoreboard bench: writers queue the expected byte stream, a monitor checks
// every tx_start, and a responder plays the UART.
module tb_mips_uart_tx_ctrl;
    localparam int LENGTH = 32;
    localparam int DEPTH  = 4;
    localparam int BYTES  = LENGTH / 8;

    logic clock = 1'b0;
    logic reset;
    logic resp_done;
    logic man_done;

    always #5 clock = ~clock;

    mips_uart_tx_ctrl_if #(.LENGTH(LENGTH), .DEPTH(DEPTH)) bus ();
    mips_uart_tx_ctrl #(.LENGTH(LENGTH), .DEPTH(DEPTH)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    assign bus.UART_Done = resp_done | man_done;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    int starts = 0;
    int acked = 0;
    int pos = 0;
    int words_done = 0;
    int words_acc = 0;
    int ncyc = 0;
    int rise_ncyc = 0;
    bit have_rise = 0;
    bit chk_gap = 0;
    bit resp_en = 0;
    bit resp_rand = 0;
    int dly_cfg = 3;
    int hold_cfg = 5;
    int fill_cnt[6] = '{1, 2, 2, 3, 4, 4};
    int fill_full[6] = '{0, 0, 0, 0, 1, 1};
    int fill_ovf[6] = '{0, 0, 0, 0, 0, 1};

    always @(posedge clock) ncyc <= ncyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic exp_word(input logic [31:0] w);
        for (int i = 0; i < BYTES; i++) exp_q.push_back(w[8*i +: 8]);
        words_acc++;
    endtask

    task automatic put(input logic [31:0] w, input bit accept);
        bus.wr_en   = 1'b1;
        bus.wr_data = w;
        if (accept) exp_word(w);
        @(negedge clock);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((bus.busy !== 1'b0 || exp_q.size() != 0) && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk({name, "_drained"}, 32'(exp_q.size()), 0);
        chk({name, "_busy"}, 32'(bus.busy), 0);
    endtask

    // Monitor: every tx_start must carry the next queued byte.
    initial begin
        forever begin
            @(negedge clock);
            if (bus.tx_start === 1'b1) begin
                starts++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_tx_start: tx_byte=%0h with nothing queued", bus.tx_byte);
                end else begin
                    chk("tx_byte", 32'(bus.tx_byte), 32'(exp_q.pop_front()));
                end
                if (chk_gap && have_rise) chk("gap", ncyc - rise_ncyc, (pos == 0) ? 3 : 1);
                pos++;
                if (pos == BYTES) begin
                    pos = 0;
                    words_done++;
                end
            end
        end
    end

    // UART model: one done pulse per outstanding tx_start.
    initial begin
        int phase;
        int timer;
        phase = 0;
        timer = 0;
        resp_done = 1'b0;
        forever begin
            @(negedge clock);
            if (!resp_en) begin
                phase = 0;
                resp_done = 1'b0;
            end else begin
                case (phase)
                    0: if (starts > acked) begin
                        acked++;
                        timer = resp_rand ? int'($urandom_range(1, 4)) : dly_cfg;
                        phase = 1;
                    end
                    1: if (timer > 1) timer--;
                    else begin
                        resp_done = 1'b1;
                        rise_ncyc = ncyc;
                        have_rise = 1;
                        timer = resp_rand ? int'($urandom_range(1, 3)) : hold_cfg;
                        phase = 2;
                    end
                    2: if (timer > 1) timer--;
                    else begin
                        resp_done = 1'b0;
                        phase = 0;
                    end
                    default: phase = 0;
                endcase
            end
        end
    end

    initial begin
        int s0;
        int n;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        man_done    = 1'b0;
        reset       = 1'b1;
        repeat (3) tick();
        chk("rst_tx_start", 32'(bus.tx_start), 0);
        chk("rst_tx_byte", 32'(bus.tx_byte), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_overflow", 32'(bus.overflow), 0);
        reset = 1'b0;
        tick();

        // Single word with exact first-byte latency.
        resp_en = 1;
        dly_cfg = 3;
        hold_cfg = 5;
        put(32'hA1B2C3D4, 1);
        bus.wr_en = 1'b0;
        chk("single_count", 32'(bus.count), 1);
        chk("single_start_k", 32'(bus.tx_start), 0);
        tick();
        chk("single_start_k1", 32'(bus.tx_start), 0);
        tick();
        chk("single_start_k2", 32'(bus.tx_start), 1);
        chk("single_byte0", 32'(bus.tx_byte), 32'hD4);
        wait_idle("single", 200);
        chk("single_pulses", starts, 4);
        chk("single_count_end", 32'(bus.count), 0);

        // UART_Done already high when WAIT is entered.
        resp_en = 0;
        repeat (8) tick();
        man_done = 1'b1;
        repeat (2) tick();
        s0 = starts;
        put(32'h0F1E2D3C, 1);
        bus.wr_en = 1'b0;
        repeat (20) tick();
        chk("held_one_byte", starts - s0, 1);
        man_done = 1'b0;
        tick();
        man_done = 1'b1;
        repeat (3) tick();
        chk("held_second_byte", starts - s0, 2);
        repeat (10) tick();
        chk("held_no_more", starts - s0, 2);
        repeat (3) begin
            man_done = 1'b0;
            repeat (2) tick();
            man_done = 1'b1;
            repeat (2) tick();
        end
        man_done = 1'b0;
        wait_idle("held", 100);
        chk("held_pulses", starts - s0, 4);

        // Fill, simultaneous push/pop, overflow, pointer wrap.
        repeat (3) tick();
        acked = starts;
        s0 = starts;
        for (int i = 0; i < 6; i++) begin
            put($urandom, i < 5);
            chk($sformatf("fill_count_%0d", i), 32'(bus.count), fill_cnt[i]);
            chk($sformatf("fill_full_%0d", i), 32'(bus.full), fill_full[i]);
            chk($sformatf("fill_ovf_%0d", i), 32'(bus.overflow), fill_ovf[i]);
        end
        bus.wr_en = 1'b0;
        repeat (5) tick();
        chk("fill_hold_count", 32'(bus.count), 4);
        chk("fill_one_start", starts - s0, 1);
        resp_en = 1;
        wait_idle("fill", 800);
        chk("fill_ovf_sticky", 32'(bus.overflow), 1);
        chk("fill_full_end", 32'(bus.full), 0);

        // Back-to-back words with IDLE/LOAD gap check.
        dly_cfg = 2;
        hold_cfg = 3;
        repeat (3) tick();
        have_rise = 0;
        chk_gap = 1;
        put(32'h11223344, 1);
        put(32'h55667788, 1);
        put(32'h99AABBCC, 1);
        bus.wr_en = 1'b0;
        wait_idle("b2b", 600);
        chk_gap = 0;

        // Asynchronous reset after the second byte of a word.
        repeat (3) tick();
        s0 = starts;
        put($urandom, 1);
        put($urandom, 1);
        bus.wr_en = 1'b0;
        n = 0;
        while (starts < s0 + 2 && n < 200) begin
            tick();
            n++;
        end
        chk("rst_mid_reach", starts - s0, 2);
        #2;
        reset = 1'b1;
        resp_en = 0;
        man_done = 1'b0;
        exp_q.delete();
        pos = 0;
        words_acc = 0;
        words_done = 0;
        #1;
        chk("rst_mid_tx_start", 32'(bus.tx_start), 0);
        chk("rst_mid_count", 32'(bus.count), 0);
        chk("rst_mid_busy", 32'(bus.busy), 0);
        chk("rst_mid_tx_byte", 32'(bus.tx_byte), 0);
        chk("rst_mid_overflow", 32'(bus.overflow), 0);
        repeat (2) tick();
        reset = 1'b0;
        acked = starts;
        s0 = starts;
        repeat (15) tick();
        chk("rst_mid_silent", starts - s0, 0);
        resp_en = 1;
        put(32'hC0FFEE42, 1);
        bus.wr_en = 1'b0;
        wait_idle("rst_restart", 200);
        chk("rst_restart_pulses", starts - s0, 4);

        // Randomized traffic against the byte-stream model.
        resp_rand = 1;
        for (int i = 0; i < 30; i++) begin
            n = 0;
            while (words_acc - words_done >= DEPTH && n < 400) begin
                tick();
                n++;
            end
            chk("rand_room", 32'(n < 400), 1);
            put($urandom, 1);
            bus.wr_en = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_idle("rand", 4000);
        chk("rand_overflow", 32'(bus.overflow), 0);
        chk("rand_count", 32'(bus.count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
